// File: rtl/cpu_hatch_pkg.sv
// Shared constants for the stack CPU instruction hatch: word geometry, NOP encoding, hatch states.
package cpu_hatch_pkg;

  localparam int unsigned INSN_WIDTH = 48;
  localparam int unsigned INSN_BYTES = 6;
  localparam logic [INSN_WIDTH-1:0] NOP_ENC = 48'h0;

  typedef enum logic {
    HATCH_LOAD = 1'b0,
    HATCH_RUN  = 1'b1
  } hatch_state_e;

endpackage

// File: rtl/cpu_hatch_if.sv
// Program-load byte stream plus the fetch port between the hatch and the CPU.
interface cpu_hatch_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);

  logic                                  load_valid;
  logic [7:0]                            load_data;
  logic                                  load_last;
  logic                                  load_ready;
  logic                                  loaded;
  logic                                  load_error;
  logic [DEPTH_LOG2:0]                   load_count;
  logic                                  cpu_rst_b;
  logic [31:0]                           hatch_address;
  logic [cpu_hatch_pkg::INSN_WIDTH-1:0]  hatch_instruction;

  modport master (
    output load_valid, load_data, load_last, hatch_address,
    input  load_ready, loaded, load_error, load_count, cpu_rst_b, hatch_instruction
  );

  modport slave (
    input  load_valid, load_data, load_last, hatch_address,
    output load_ready, loaded, load_error, load_count, cpu_rst_b, hatch_instruction
  );

endinterface

// File: rtl/cpu_hatch_mem.sv
// Instruction store: synchronous write, asynchronous read, no reset.
// Contents survive hatch reset; the top masks stale words with load_count.
module cpu_hatch_mem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_hatch.sv
// Instruction hatch: packs a byte stream into 48-bit words, holds the CPU in reset until loaded.
// Word readable the cycle after its sixth byte; fetch read is same-cycle; load_ready drops in RUN.
module cpu_hatch
  import cpu_hatch_pkg::*;
#(
  parameter int unsigned           DEPTH_LOG2 = 10,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN   = NOP_ENC
) (
  input logic        clk,
  input logic        rst_b,
  cpu_hatch_if.slave hif
);

  localparam logic [2:0]          BCNT_LAST = 3'(INSN_BYTES - 1);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE = (DEPTH_LOG2+1)'(1);

  hatch_state_e            state_q;
  logic [2:0]              bcnt_q, bcnt_d;
  logic [INSN_WIDTH-9:0]   asm_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    err_q, err_d;
  logic                    cpu_rst_q;
  logic                    accept, word_done, full, wr_en, hit;
  logic [INSN_WIDTH-1:0]   word_d, rd_data;

  assign accept    = hif.load_valid && (state_q == HATCH_LOAD);
  assign word_done = accept && (bcnt_q == BCNT_LAST);
  // load_count saturates at 2^DEPTH_LOG2, so its MSB alone marks a full memory
  assign full      = count_q[DEPTH_LOG2];
  assign wr_en     = word_done && !full;
  assign word_d    = {asm_q, hif.load_data};

  always_comb begin
    bcnt_d  = bcnt_q;
    count_d = count_q;
    err_d   = err_q;
    if (accept) begin
      bcnt_d = word_done ? 3'd0 : bcnt_q + 3'd1;
      if (wr_en) count_d = count_q + COUNT_ONE;
      if (word_done && full) err_d = 1'b1;
      if (hif.load_last && !word_done) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= HATCH_LOAD;
      bcnt_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
      asm_q     <= '0;
    end else begin
      bcnt_q    <= bcnt_d;
      count_q   <= count_d;
      err_q     <= err_d;
      // one cycle behind RUN so the whole program is visible before the first fetch
      cpu_rst_q <= (state_q == HATCH_RUN);
      if (accept) begin
        asm_q <= word_d[INSN_WIDTH-9:0];
        if (hif.load_last) state_q <= HATCH_RUN;
      end
    end
  end

  cpu_hatch_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (INSN_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(count_q[DEPTH_LOG2-1:0]),
    .wdata_i(word_d),
    .raddr_i(hif.hatch_address[DEPTH_LOG2-1:0]),
    .rdata_o(rd_data)
  );

  // full 32-bit compare so high address bits cannot alias into the array
  assign hit = (32'(count_q) > hif.hatch_address);

  assign hif.load_ready        = (state_q == HATCH_LOAD);
  assign hif.loaded            = (state_q == HATCH_RUN);
  assign hif.load_error        = err_q;
  assign hif.load_count        = count_q;
  assign hif.cpu_rst_b         = cpu_rst_q;
  assign hif.hatch_instruction = hit ? rd_data : NOP_INSN;

endmodule

// File: tb/tb_cpu_hatch.sv
// Bench for cpu_hatch: a deep instance with a non-zero NOP and a 4-word instance for overflow.
module tb_cpu_hatch;
  import cpu_hatch_pkg::*;

  typedef logic [7:0] byteq_t [$];

  localparam logic [47:0] BIG_NOP   = 48'hA5A5_0000_5A5A;
  localparam logic [47:0] SMALL_NOP = 48'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big_b, rst_small_b;

  cpu_hatch_if #(.DEPTH_LOG2(10)) hb();
  cpu_hatch_if #(.DEPTH_LOG2(2))  hs();

  cpu_hatch #(.DEPTH_LOG2(10), .NOP_INSN(BIG_NOP)) u_big (
    .clk  (clk),
    .rst_b(rst_big_b),
    .hif  (hb)
  );

  cpu_hatch #(.DEPTH_LOG2(2)) u_small (
    .clk  (clk),
    .rst_b(rst_small_b),
    .hif  (hs)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference: a program is just a byte list; word k is bytes 6k..6k+5, first byte most significant
  function automatic logic [47:0] m_word(input byteq_t q, input int k);
    logic [47:0] w = '0;
    for (int j = 0; j < 6; j++) w = (w << 8) | 48'(q[6*k+j]);
    return w;
  endfunction

  function automatic int m_count(input byteq_t q, input int depth);
    int n = q.size() / 6;
    return (n > depth) ? depth : n;
  endfunction

  function automatic logic m_err(input byteq_t q, input int depth);
    return ((q.size() % 6) != 0) || ((q.size() / 6) > depth);
  endfunction

  function automatic byteq_t rand_bytes(input int n);
    byteq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // {load_ready, loaded, load_error, cpu_rst_b}
  function automatic logic [3:0] stat(input bit sm);
    return sm ? {hs.load_ready, hs.loaded, hs.load_error, hs.cpu_rst_b}
              : {hb.load_ready, hb.loaded, hb.load_error, hb.cpu_rst_b};
  endfunction

  function automatic logic [10:0] cnt(input bit sm);
    return sm ? 11'(hs.load_count) : hb.load_count;
  endfunction

  task automatic put(input bit sm, input logic v, input logic [7:0] d, input logic l);
    if (sm) begin
      hs.load_valid = v; hs.load_data = d; hs.load_last = l;
    end else begin
      hb.load_valid = v; hb.load_data = d; hb.load_last = l;
    end
  endtask

  task automatic read_insn(input bit sm, input logic [31:0] a, output logic [47:0] w);
    if (sm) hs.hatch_address = a;
    else    hb.hatch_address = a;
    #1;
    w = sm ? hs.hatch_instruction : hb.hatch_instruction;
  endtask

  task automatic do_reset(input bit sm, input int cycles);
    @(negedge clk);
    if (sm) rst_small_b = 1'b0; else rst_big_b = 1'b0;
    repeat (cycles) @(negedge clk);
    if (sm) rst_small_b = 1'b1; else rst_big_b = 1'b1;
  endtask

  // streams q; gap cycles inserted with probability gap_pct; counts ready-low and cpu_rst-high cycles
  task automatic load_prog(input bit sm, input byteq_t q, input int gap_pct, input bit with_last,
                           output int ready_bad, output int crst_bad);
    ready_bad = 0;
    crst_bad  = 0;
    for (int i = 0; i < q.size(); i++) begin
      for (int g = 0; g < 20 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
        if (stat(sm) !== 4'b1000 && stat(sm) !== 4'b1010) ready_bad++;
        if (stat(sm)[0] !== 1'b0) crst_bad++;
        put(sm, 1'b0, 8'($urandom), 1'($urandom));
        @(negedge clk);
      end
      if (stat(sm)[3] !== 1'b1) ready_bad++;
      if (stat(sm)[0] !== 1'b0) crst_bad++;
      put(sm, 1'b1, q[i], with_last && (i == q.size() - 1));
      @(negedge clk);
      put(sm, 1'b0, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset;
    logic [47:0] w;
    rst_big_b = 1'b0; rst_small_b = 1'b0;
    put(0, 1'b0, 8'h0, 1'b0); put(1, 1'b0, 8'h0, 1'b0);
    hb.hatch_address = '0; hs.hatch_address = '0;
    repeat (3) @(negedge clk);
    vectors++; if (stat(0) !== 4'b1000) begin miscompares++; $display("FAIL reset_status got=%b exp=1000", stat(0)); end
    vectors++; if (cnt(0) !== 11'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", cnt(0)); end
    vectors++; if (stat(1) !== 4'b1000) begin miscompares++; $display("FAIL reset_status_small got=%b exp=1000", stat(1)); end
    read_insn(0, 32'd0, w);
    vectors++; if (w !== BIG_NOP) begin miscompares++; $display("FAIL reset_read0 got=%h exp=%h", w, BIG_NOP); end
    rst_big_b = 1'b1; rst_small_b = 1'b1;
    @(negedge clk);
    vectors++; if (stat(0) !== 4'b1000) begin miscompares++; $display("FAIL post_release got=%b exp=1000", stat(0)); end
  endtask

  task automatic test_basic;
    byteq_t q;
    int rb, cb;
    logic [47:0] w;
    for (int i = 1; i <= 12; i++) q.push_back(8'(i));
    load_prog(0, q, 0, 1'b1, rb, cb);
    vectors++; if (stat(0) !== 4'b0100) begin miscompares++; $display("FAIL basic_loaded got=%b exp=0100", stat(0)); end
    vectors++; if (cnt(0) !== 11'd2) begin miscompares++; $display("FAIL basic_count got=%0d exp=2", cnt(0)); end
    vectors++; if (rb != 0 || cb != 0) begin miscompares++; $display("FAIL basic_load_flags ready_bad=%0d crst_bad=%0d exp=0", rb, cb); end
    @(negedge clk);
    vectors++; if (stat(0) !== 4'b0101) begin miscompares++; $display("FAIL basic_cpu_rst_rise got=%b exp=0101", stat(0)); end
    read_insn(0, 32'd0, w);
    vectors++; if (w !== 48'h010203040506) begin miscompares++; $display("FAIL basic_word0 got=%h exp=010203040506", w); end
    read_insn(0, 32'd1, w);
    vectors++; if (w !== 48'h0708090A0B0C) begin miscompares++; $display("FAIL basic_word1 got=%h exp=0708090a0b0c", w); end
    read_insn(0, 32'd2, w);
    vectors++; if (w !== BIG_NOP) begin miscompares++; $display("FAIL basic_word2_nop got=%h exp=%h", w, BIG_NOP); end
    read_insn(0, 32'h8000_0000, w);
    vectors++; if (w !== BIG_NOP) begin miscompares++; $display("FAIL basic_high_addr got=%h exp=%h", w, BIG_NOP); end
    test_run_ignores(q);
  endtask

  task automatic test_run_ignores(input byteq_t q);
    int bad = 0;
    logic [47:0] w;
    for (int i = 0; i < 8; i++) begin
      put(0, 1'b1, 8'($urandom), 1'($urandom));
      @(negedge clk);
      if (stat(0) !== 4'b0101) bad++;
    end
    put(0, 1'b0, 8'h0, 1'b0);
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL run_status_bad_cycles got=%0d exp=0", bad); end
    vectors++; if (cnt(0) !== 11'(m_count(q, 1024))) begin miscompares++; $display("FAIL run_count got=%0d exp=%0d", cnt(0), m_count(q, 1024)); end
    for (int k = 0; k < 3; k++) begin
      logic [47:0] e = (k < m_count(q, 1024)) ? m_word(q, k) : BIG_NOP;
      read_insn(0, 32'(k), w);
      vectors++; if (w !== e) begin miscompares++; $display("FAIL run_word%0d got=%h exp=%h", k, w, e); end
    end
  endtask

  task automatic test_gappy;
    byteq_t q = rand_bytes(60);
    int rb, cb;
    logic [47:0] w;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(0, 2);
      load_prog(0, q, pass * 50, 1'b1, rb, cb);
      vectors++; if (rb != 0 || cb != 0) begin miscompares++; $display("FAIL gap%0d_flags ready_bad=%0d crst_bad=%0d exp=0", pass, rb, cb); end
      vectors++; if (cnt(0) !== 11'd10 || stat(0) !== {3'b010, m_err(q, 1024)}) begin
        miscompares++; $display("FAIL gap%0d_status count=%0d stat=%b exp count=10 stat=0100", pass, cnt(0), stat(0));
      end
      for (int k = 0; k <= 10; k++) begin
        logic [47:0] e = (k < 10) ? m_word(q, k) : BIG_NOP;
        read_insn(0, 32'(k), w);
        vectors++; if (w !== e) begin miscompares++; $display("FAIL gap%0d_word%0d got=%h exp=%h", pass, k, w, e); end
      end
    end
  endtask

  task automatic test_truncated;
    byteq_t q = rand_bytes(8);
    int rb, cb;
    logic [47:0] w;
    do_reset(0, 2);
    load_prog(0, q, 0, 1'b1, rb, cb);
    vectors++; if (stat(0) !== {3'b011, 1'b0} || !m_err(q, 1024)) begin miscompares++; $display("FAIL trunc_status got=%b exp=0110", stat(0)); end
    vectors++; if (cnt(0) !== 11'(m_count(q, 1024))) begin miscompares++; $display("FAIL trunc_count got=%0d exp=%0d", cnt(0), m_count(q, 1024)); end
    read_insn(0, 32'd0, w);
    vectors++; if (w !== m_word(q, 0)) begin miscompares++; $display("FAIL trunc_word0 got=%h exp=%h", w, m_word(q, 0)); end
    read_insn(0, 32'd1, w);
    vectors++; if (w !== BIG_NOP) begin miscompares++; $display("FAIL trunc_word1_nop got=%h exp=%h", w, BIG_NOP); end
    @(negedge clk);
    vectors++; if (stat(0) !== 4'b0111) begin miscompares++; $display("FAIL trunc_cpu_rst got=%b exp=0111", stat(0)); end
    // reset from RUN: CPU reset must drop the cycle after rst_b is sampled low
    rst_big_b = 1'b0;
    @(negedge clk);
    vectors++; if (stat(0) !== 4'b1000 || cnt(0) !== 11'd0) begin miscompares++; $display("FAIL run_reset got stat=%b count=%0d exp stat=1000 count=0", stat(0), cnt(0)); end
    read_insn(0, 32'd0, w);
    vectors++; if (w !== BIG_NOP) begin miscompares++; $display("FAIL run_reset_mask got=%h exp=%h", w, BIG_NOP); end
    rst_big_b = 1'b1;
  endtask

  task automatic test_overflow;
    byteq_t q = rand_bytes(30);
    int rb, cb;
    logic [47:0] w;
    do_reset(1, 2);
    load_prog(1, q, 0, 1'b1, rb, cb);
    vectors++; if (stat(1) !== {3'b011, 1'b0} || !m_err(q, 4)) begin miscompares++; $display("FAIL ovf_status got=%b exp=0110", stat(1)); end
    vectors++; if (cnt(1) !== 11'(m_count(q, 4))) begin miscompares++; $display("FAIL ovf_count got=%0d exp=%0d", cnt(1), m_count(q, 4)); end
    vectors++; if (rb != 0) begin miscompares++; $display("FAIL ovf_ready got=%0d exp=0", rb); end
    for (int k = 0; k < 4; k++) begin
      read_insn(1, 32'(k), w);
      vectors++; if (w !== m_word(q, k)) begin miscompares++; $display("FAIL ovf_word%0d got=%h exp=%h", k, w, m_word(q, k)); end
    end
    read_insn(1, 32'd4, w);
    vectors++; if (w !== SMALL_NOP) begin miscompares++; $display("FAIL ovf_addr4 got=%h exp=%h", w, SMALL_NOP); end
    read_insn(1, 32'h0000_0101, w);
    vectors++; if (w !== SMALL_NOP) begin miscompares++; $display("FAIL ovf_alias got=%h exp=%h", w, SMALL_NOP); end
  endtask

  task automatic test_reset_midload;
    byteq_t q1 = rand_bytes(15);
    byteq_t q2 = rand_bytes(6);
    int rb, cb;
    logic [47:0] w;
    do_reset(0, 2);
    load_prog(0, q1, 0, 1'b0, rb, cb);
    vectors++; if (cnt(0) !== 11'd2 || stat(0) !== 4'b1000) begin miscompares++; $display("FAIL mid_pre got count=%0d stat=%b exp count=2 stat=1000", cnt(0), stat(0)); end
    // a byte flagged last on the reset edge must be ignored
    rst_big_b = 1'b0;
    put(0, 1'b1, 8'($urandom), 1'b1);
    @(negedge clk);
    rst_big_b = 1'b1;
    put(0, 1'b0, 8'h0, 1'b0);
    vectors++; if (cnt(0) !== 11'd0 || stat(0) !== 4'b1000) begin miscompares++; $display("FAIL mid_reset got count=%0d stat=%b exp count=0 stat=1000", cnt(0), stat(0)); end
    load_prog(0, q2, 50, 1'b1, rb, cb);
    vectors++; if (cb != 0) begin miscompares++; $display("FAIL mid_cpu_rst_early got=%0d exp=0", cb); end
    vectors++; if (cnt(0) !== 11'd1 || stat(0) !== 4'b0100) begin miscompares++; $display("FAIL mid_reload got count=%0d stat=%b exp count=1 stat=0100", cnt(0), stat(0)); end
    read_insn(0, 32'd0, w);
    vectors++; if (w !== m_word(q2, 0)) begin miscompares++; $display("FAIL mid_word0 got=%h exp=%h", w, m_word(q2, 0)); end
    read_insn(0, 32'd1, w);
    vectors++; if (w !== BIG_NOP) begin miscompares++; $display("FAIL mid_stale_mask got=%h exp=%h", w, BIG_NOP); end
    @(negedge clk);
    vectors++; if (stat(0) !== 4'b0101) begin miscompares++; $display("FAIL mid_cpu_rst_rise got=%b exp=0101", stat(0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gappy();
    test_truncated();
    test_overflow();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_hatch.md
# cpu_hatch

Instruction hatch for the pipelined stack CPU. It accepts a program as a byte stream over a valid/ready handshake and packs each six bytes into one 48-bit instruction word in local instruction memory. While loading, it holds the CPU in reset. Once loaded, it serves the CPU's fetch requests (`hatch_address` → `hatch_instruction`). It sits directly upstream of the CPU's fetch stage and is the only source of instructions.

## Interface
- `DEPTH_LOG2`, default 10: log2 of instruction memory depth in words.
- `NOP_INSN`, default 48'h0: word returned for unloaded or out-of-range addresses.

Ports:
- `clk`  in  1  single clock.
- `rst_b`  in  1  reset; synchronous, active-low.
- `load_valid`  in  1  byte offered on `load_data`.
- `load_data`  in  8  program byte, big-endian within each instruction (first byte = bits 47:40).
- `load_last`  in  1  qualifies the final byte of the program; sampled with `load_valid`.
- `load_ready`  out  1  hatch accepts a byte this cycle.
- `loaded`  out  1  program load complete (RUN state).
- `load_error`  out  1  sticky: truncated final word or memory overflow.
- `load_count`  out  DEPTH_LOG2+1  number of complete instruction words written.
- `cpu_rst_b`  out  1  synchronous active-low reset to the CPU.
- `hatch_address`  in  32  instruction index (word address) from fetch.
- `hatch_instruction`  out  48  instruction at `hatch_address`.

## Operation
- States:
  - LOAD (reset state).
  - RUN.
- LOAD → RUN on the accepted byte with `load_last`=1.
- RUN is left only by `rst_b`=0.
- A byte is accepted when `load_valid && load_ready` at a rising edge.
- `load_ready` = 1 in LOAD, 0 in RUN.
- Byte counter `bcnt` runs 0..5. Bytes shift into a 48-bit assembly register.
  - On the accepted byte with `bcnt`=5, the assembled word is written to `mem[load_count]`.
  - At that same edge, `load_count` increments and `bcnt` wraps to 0.
- Truncated final word (`load_last` on a byte with `bcnt`≠5):
  - The partial word is discarded and not written.
  - `load_error` is set.
  - The transition to RUN still occurs.
- Overflow (`load_count` = 2^DEPTH_LOG2 and a word completes):
  - The word is dropped and `load_count` saturates.
  - `load_error` is set.
  - Further bytes are still accepted until `load_last`.
- Read path is combinational:
  - `hatch_instruction` = `mem[hatch_address]` if `hatch_address` < `load_count`.
  - Otherwise it is `NOP_INSN`. This includes any upper address bits being nonzero.
- Memory is never cleared. Stale contents are masked by the `load_count` compare.
- `rst_b`=0 at any time, including mid-load or mid-word:
  - State → LOAD.
  - `bcnt` = 0, `load_count` = 0, `load_error` = 0.
  - `cpu_rst_b` = 0.
  - Any partial word is lost.

## Timing
- Reset values:
  - `load_ready`=1, `loaded`=0, `load_error`=0, `load_count`=0, `cpu_rst_b`=0.
  - `hatch_instruction` = `NOP_INSN`.
- Word write latency: the word is readable on `hatch_instruction` in the cycle after its sixth byte is accepted.
- `loaded` rises at the edge accepting the last byte.
- `cpu_rst_b` is registered from state and rises one cycle after `loaded`. The CPU therefore fetches address 0 with the complete program already visible.
- `cpu_rst_b` falls in the cycle after `rst_b` is sampled low. Through the same cycle it is held low for as long as `rst_b` stays low.
- Read latency: zero cycles (address to data, same cycle). `hatch_address` must not be registered inside the hatch.
- The `rst_b` branch has priority over an accepted byte on the same edge.

## Structure
- Shared constants go in the CPU defines include:
  - `INSN_WIDTH` (48).
  - `INSN_BYTES` (6).
  - NOP encoding.
  - State encodings `HATCH_LOAD` / `HATCH_RUN`.
- One sub-module, `cpu_hatch_mem`:
  - 2^DEPTH_LOG2 × 48 array.
  - Synchronous write port and asynchronous read port.
  - No reset.
- Top level holds:
  - the FSM;
  - the byte counter and assembly register;
  - the `load_count` / error logic;
  - the read mask mux.

## Test plan
- Stream 12 bytes 01..0C with `load_last` on 0C →
  - `load_count`=2, `loaded`=1, `load_error`=0;
  - `cpu_rst_b` rises one cycle later;
  - address 0 reads 48'h010203040506, address 1 reads 48'h0708090A0B0C, address 2 reads `NOP_INSN`.
- `load_valid` toggled randomly (≈50%) during a 10-word load → words are identical to the gap-free load, and `load_ready` stays 1 throughout LOAD.
- 8 bytes with `load_last` on byte 8 → `load_count`=1, `load_error`=1, address 1 reads `NOP_INSN`, RUN is entered.
- With `DEPTH_LOG2`=2, load 5 words → `load_count`=4, `load_error`=1, and words 0..3 are intact.
- `rst_b` pulsed low after 3 bytes of word 2, then a 1-word program is reloaded → `load_count`=1, address 1 reads `NOP_INSN` despite stale memory, and `cpu_rst_b` stays low until reload completes.
- In RUN, assert `load_valid` → no byte accepted, and `load_count` and memory are unchanged.
